// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ring_pkg
//  Purpose  : Shared types and constants for the packet ring stops.
//             - ring_pkt_t : packet as carried on the ring (valid + fields),
//                            sized at the default stop widths
//             - PKT_*      : packet type encodings carried in the 3-bit type
//  Revision : 1.0 - initial release
// ============================================================================
package ring_pkg;

    localparam int RING_DATA_W = 512;
    localparam int RING_ADDR_W = 36;
    localparam int RING_ID_W   = 5;
    localparam int RING_TYPE_W = 3;

    localparam logic [RING_TYPE_W-1:0] PKT_READ  = 3'd0;
    localparam logic [RING_TYPE_W-1:0] PKT_WRITE = 3'd1;
    localparam logic [RING_TYPE_W-1:0] PKT_RESP  = 3'd2;
    localparam logic [RING_TYPE_W-1:0] PKT_ACK   = 3'd3;

    typedef struct packed {
        logic                   valid;
        logic [RING_ADDR_W-1:0] addr;
        logic [RING_DATA_W-1:0] data;
        logic [RING_ID_W-1:0]   id;
        logic [RING_TYPE_W-1:0] pkt_type;
    } ring_pkt_t;

endpackage
`default_nettype wire

// File: rtl/ring_inject_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ring_inject_fifo
//  Purpose  : Small synchronous FIFO holding locally queued ring packets.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-low reset (clears pointers/count)
//             push_valid - write request (already qualified by the caller)
//             push_ready - space available (registered-count based)
//             push_data  - packet fields to store
//             pop        - remove head entry (ignored when empty)
//             pop_data   - head entry
//             count      - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module ring_inject_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // No same-cycle pop bypass: a full FIFO refuses pushes even when popping.
    assign push_ready = (r_count < c_CNT_W'(DEPTH));
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && (r_count != '0);
    assign pop_data   = r_mem[r_rd_ptr];
    assign count      = r_count;

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_node_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ring_node_stage
//  Purpose  : Registered stop on a unidirectional packet ring. Ejects packets
//             addressed to NODE_ID into a local output register, bounces them
//             around the ring when that register is busy, and inserts queued
//             local packets into empty slots. One register stage per hop.
//  Ports    : clk, rst (async active-low)
//             ring_in_*  - packet from upstream stop
//             ring_out_* - registered packet to downstream stop
//             inj_*      - local inject request (valid/ready), inj_id = dest
//             ej_*       - ejected packet to local client (valid/ready)
//             inj_count  - inject FIFO occupancy
//             bounce_cnt - saturating count of matched packets that bounced
//             stall_cnt  - saturating count of cycles with queued packets and
//                          no free slot
//  Revision : 1.0 - initial release
// ============================================================================
module ring_node_stage
    import ring_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 36,
    parameter int ID_W      = 5,
    parameter int NODE_ID   = 0,
    parameter int INJ_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       ring_in_valid,
    input  logic [ADDR_W-1:0]          ring_in_addr,
    input  logic [DATA_W-1:0]          ring_in_data,
    input  logic [ID_W-1:0]            ring_in_id,
    input  logic [RING_TYPE_W-1:0]     ring_in_type,

    output logic                       ring_out_valid,
    output logic [ADDR_W-1:0]          ring_out_addr,
    output logic [DATA_W-1:0]          ring_out_data,
    output logic [ID_W-1:0]            ring_out_id,
    output logic [RING_TYPE_W-1:0]     ring_out_type,

    input  logic                       inj_valid,
    output logic                       inj_ready,
    input  logic [ADDR_W-1:0]          inj_addr,
    input  logic [DATA_W-1:0]          inj_data,
    input  logic [ID_W-1:0]            inj_id,
    input  logic [RING_TYPE_W-1:0]     inj_type,

    output logic                       ej_valid,
    input  logic                       ej_ready,
    output logic [ADDR_W-1:0]          ej_addr,
    output logic [DATA_W-1:0]          ej_data,
    output logic [ID_W-1:0]            ej_id,
    output logic [RING_TYPE_W-1:0]     ej_type,

    output logic [$clog2(INJ_DEPTH):0] inj_count,
    output logic [CNT_W-1:0]           bounce_cnt,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int c_PKT_W = ADDR_W + DATA_W + ID_W + RING_TYPE_W;

    // ---------------- inject FIFO ----------------
    logic [c_PKT_W-1:0]          w_head;
    logic [ADDR_W-1:0]           w_head_addr;
    logic [DATA_W-1:0]           w_head_data;
    logic [ID_W-1:0]             w_head_id;
    logic [RING_TYPE_W-1:0]      w_head_type;
    logic                        w_fifo_ready;
    logic                        w_fifo_empty;
    logic                        w_insert;

    // Ready is forced low while reset is held, independent of the clock.
    assign inj_ready    = rst && w_fifo_ready;
    assign w_fifo_empty = (inj_count == '0);
    assign {w_head_addr, w_head_data, w_head_id, w_head_type} = w_head;

    ring_inject_fifo #(
        .WIDTH (c_PKT_W),
        .DEPTH (INJ_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (inj_valid && inj_ready),
        .push_ready (w_fifo_ready),
        .push_data  ({inj_addr, inj_data, inj_id, inj_type}),
        .pop        (w_insert),
        .pop_data   (w_head),
        .count      (inj_count)
    );

    // ---------------- slot decisions ----------------
    logic w_match;
    logic w_ej_free;
    logic w_eject;
    logic w_bounce;
    logic w_slot_free;
    logic w_stall;

    assign w_match     = ring_in_valid && (ring_in_id == ID_W'(NODE_ID));
    assign w_ej_free   = !ej_valid || ej_ready;
    assign w_eject     = w_match && w_ej_free;
    assign w_bounce    = w_match && !w_ej_free;
    // A slot freed by our own eject can be refilled in the same cycle.
    assign w_slot_free = !ring_in_valid || w_eject;
    assign w_insert    = w_slot_free && !w_fifo_empty;
    assign w_stall     = !w_fifo_empty && !w_slot_free;

    // ---------------- ring output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_out_valid <= 1'b0;
            ring_out_addr  <= '0;
            ring_out_data  <= '0;
            ring_out_id    <= '0;
            ring_out_type  <= '0;
        end else if (w_insert) begin
            ring_out_valid <= 1'b1;
            ring_out_addr  <= w_head_addr;
            ring_out_data  <= w_head_data;
            ring_out_id    <= w_head_id;
            ring_out_type  <= w_head_type;
        end else begin
            // Ejected-and-not-refilled slot goes out empty; fields are
            // don't-care then, so they simply follow ring_in.
            ring_out_valid <= ring_in_valid && !w_eject;
            ring_out_addr  <= ring_in_addr;
            ring_out_data  <= ring_in_data;
            ring_out_id    <= ring_in_id;
            ring_out_type  <= ring_in_type;
        end
    end

    // ---------------- eject register ----------------
    // Fields only load on an eject, so they hold while the client stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_valid <= 1'b0;
            ej_addr  <= '0;
            ej_data  <= '0;
            ej_id    <= '0;
            ej_type  <= '0;
        end else if (w_eject) begin
            ej_valid <= 1'b1;
            ej_addr  <= ring_in_addr;
            ej_data  <= ring_in_data;
            ej_id    <= ring_in_id;
            ej_type  <= ring_in_type;
        end else if (ej_ready) begin
            ej_valid <= 1'b0;
        end
    end

    // ---------------- saturating statistics ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bounce_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (w_bounce && (bounce_cnt != '1)) begin
                bounce_cnt <= bounce_cnt + CNT_W'(1);
            end
            if (w_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_node_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_node_stage
//  Purpose  : Directed self-checking bench for ring_node_stage (NODE_ID = 3):
//             pass-through, eject, bounce, inject priority/ordering,
//             eject+insert in one slot, asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_node_stage;
    import ring_pkg::*;

    localparam int c_DATA_W = 512;
    localparam int c_ADDR_W = 36;
    localparam int c_ID_W   = 5;
    localparam int c_DEPTH  = 4;
    localparam int c_CNT_W  = 16;

    logic                     clk;
    logic                     rst;
    logic                     ring_in_valid;
    logic [c_ADDR_W-1:0]      ring_in_addr;
    logic [c_DATA_W-1:0]      ring_in_data;
    logic [c_ID_W-1:0]        ring_in_id;
    logic [2:0]               ring_in_type;
    logic                     ring_out_valid;
    logic [c_ADDR_W-1:0]      ring_out_addr;
    logic [c_DATA_W-1:0]      ring_out_data;
    logic [c_ID_W-1:0]        ring_out_id;
    logic [2:0]               ring_out_type;
    logic                     inj_valid;
    logic                     inj_ready;
    logic [c_ADDR_W-1:0]      inj_addr;
    logic [c_DATA_W-1:0]      inj_data;
    logic [c_ID_W-1:0]        inj_id;
    logic [2:0]               inj_type;
    logic                     ej_valid;
    logic                     ej_ready;
    logic [c_ADDR_W-1:0]      ej_addr;
    logic [c_DATA_W-1:0]      ej_data;
    logic [c_ID_W-1:0]        ej_id;
    logic [2:0]               ej_type;
    logic [$clog2(c_DEPTH):0] inj_count;
    logic [c_CNT_W-1:0]       bounce_cnt;
    logic [c_CNT_W-1:0]       stall_cnt;

    int r_checks = 0;
    int r_fails  = 0;

    ring_node_stage #(
        .DATA_W    (c_DATA_W),
        .ADDR_W    (c_ADDR_W),
        .ID_W      (c_ID_W),
        .NODE_ID   (3),
        .INJ_DEPTH (c_DEPTH),
        .CNT_W     (c_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ring_in_valid  (ring_in_valid),
        .ring_in_addr   (ring_in_addr),
        .ring_in_data   (ring_in_data),
        .ring_in_id     (ring_in_id),
        .ring_in_type   (ring_in_type),
        .ring_out_valid (ring_out_valid),
        .ring_out_addr  (ring_out_addr),
        .ring_out_data  (ring_out_data),
        .ring_out_id    (ring_out_id),
        .ring_out_type  (ring_out_type),
        .inj_valid      (inj_valid),
        .inj_ready      (inj_ready),
        .inj_addr       (inj_addr),
        .inj_data       (inj_data),
        .inj_id         (inj_id),
        .inj_type       (inj_type),
        .ej_valid       (ej_valid),
        .ej_ready       (ej_ready),
        .ej_addr        (ej_addr),
        .ej_data        (ej_data),
        .ej_id          (ej_id),
        .ej_type        (ej_type),
        .inj_count      (inj_count),
        .bounce_cnt     (bounce_cnt),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ring(input logic v, input logic [4:0] id, input logic [35:0] addr,
                              input logic [63:0] data, input logic [2:0] kind);
        ring_in_valid = v;
        ring_in_id    = id;
        ring_in_addr  = addr;
        ring_in_data  = c_DATA_W'(data);
        ring_in_type  = kind;
    endtask

    task automatic drive_inj(input logic v, input logic [4:0] id, input logic [35:0] addr,
                             input logic [63:0] data);
        inj_valid = v;
        inj_id    = id;
        inj_addr  = addr;
        inj_data  = c_DATA_W'(data);
        inj_type  = PKT_WRITE;
    endtask

    initial begin
        rst = 1'b0;
        ej_ready = 1'b1;
        drive_ring(1'b0, 5'd0, 36'h0, 64'h0, PKT_READ);
        drive_inj(1'b0, 5'd0, 36'h0, 64'h0);

        // ---- reset state ----
        #12;
        check_eq("rst_ring_out_valid", 64'(ring_out_valid), 64'd0);
        check_eq("rst_ej_valid",       64'(ej_valid),       64'd0);
        check_eq("rst_inj_count",      64'(inj_count),      64'd0);
        check_eq("rst_inj_ready",      64'(inj_ready),      64'd0);
        check_eq("rst_bounce_cnt",     64'(bounce_cnt),     64'd0);
        check_eq("rst_stall_cnt",      64'(stall_cnt),      64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("post_rst_inj_ready", 64'(inj_ready), 64'd1);

        // ---- pass-through ----
        drive_ring(1'b1, 5'd5, 36'h123, 64'h55, PKT_WRITE);
        step();
        check_eq("pass_valid", 64'(ring_out_valid), 64'd1);
        check_eq("pass_addr",  64'(ring_out_addr),  64'h123);
        check_eq("pass_id",    64'(ring_out_id),    64'd5);
        check_eq("pass_data",  ring_out_data[63:0], 64'h55);
        check_eq("pass_type",  64'(ring_out_type),  64'(PKT_WRITE));
        check_eq("pass_ej_valid", 64'(ej_valid),    64'd0);

        // ---- eject ----
        drive_ring(1'b1, 5'd3, 36'h40, 64'hAB, PKT_RESP);
        step();
        check_eq("ej_valid",       64'(ej_valid),       64'd1);
        check_eq("ej_data",        ej_data[63:0],       64'hAB);
        check_eq("ej_addr",        64'(ej_addr),        64'h40);
        check_eq("ej_ring_out_v",  64'(ring_out_valid), 64'd0);

        // ---- bounce: eject register full and stalled ----
        ej_ready = 1'b0;
        drive_ring(1'b1, 5'd3, 36'h77, 64'hCD, PKT_RESP);
        step();
        check_eq("bounce_fwd_valid", 64'(ring_out_valid), 64'd1);
        check_eq("bounce_fwd_data",  ring_out_data[63:0], 64'hCD);
        check_eq("bounce_fwd_id",    64'(ring_out_id),    64'd3);
        check_eq("bounce_cnt",       64'(bounce_cnt),     64'd1);
        check_eq("bounce_ej_hold",   ej_data[63:0],       64'hAB);
        check_eq("bounce_ej_valid",  64'(ej_valid),       64'd1);
        drive_ring(1'b0, 5'd0, 36'h0, 64'h0, PKT_READ);
        ej_ready = 1'b1;
        step();
        check_eq("ej_drained", 64'(ej_valid), 64'd0);

        // ---- inject with saturated ring: FIFO fills, stalls counted ----
        drive_ring(1'b1, 5'd5, 36'h999, 64'h99, PKT_READ);
        for (int i = 0; i < 4; i++) begin
            drive_inj(1'b1, 5'd9, 36'(36'h100 + i), 64'(64'hA0 + i));
            step();
            check_eq("fill_count", 64'(inj_count), 64'(i + 1));
            check_eq("fill_stall", 64'(stall_cnt), 64'(i));
        end
        check_eq("full_inj_ready", 64'(inj_ready), 64'd0);
        drive_inj(1'b0, 5'd0, 36'h0, 64'h0);
        step();
        check_eq("full_stall", 64'(stall_cnt), 64'd4);
        check_eq("full_count", 64'(inj_count), 64'd4);

        // ---- drain in order once the ring goes quiet ----
        drive_ring(1'b0, 5'd0, 36'h0, 64'h0, PKT_READ);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("drain_valid", 64'(ring_out_valid), 64'd1);
            check_eq("drain_addr",  64'(ring_out_addr),  64'(36'h100 + i));
            check_eq("drain_data",  ring_out_data[63:0], 64'(64'hA0 + i));
            check_eq("drain_count", 64'(inj_count),      64'(3 - i));
        end
        step();
        check_eq("drain_idle",  64'(ring_out_valid), 64'd0);
        check_eq("drain_stall", 64'(stall_cnt),      64'd4);

        // ---- eject + insert in the same slot ----
        drive_ring(1'b1, 5'd5, 36'h555, 64'h5, PKT_READ);
        drive_inj(1'b1, 5'd7, 36'h700, 64'h77);
        step();
        check_eq("ei_count_1", 64'(inj_count), 64'd1);
        drive_inj(1'b0, 5'd0, 36'h0, 64'h0);
        drive_ring(1'b1, 5'd3, 36'h333, 64'hEE, PKT_RESP);
        step();
        check_eq("ei_ej_valid",  64'(ej_valid),       64'd1);
        check_eq("ei_ej_data",   ej_data[63:0],       64'hEE);
        check_eq("ei_out_valid", 64'(ring_out_valid), 64'd1);
        check_eq("ei_out_id",    64'(ring_out_id),    64'd7);
        check_eq("ei_out_addr",  64'(ring_out_addr),  64'h700);
        check_eq("ei_count_0",   64'(inj_count),      64'd0);
        check_eq("ei_stall",     64'(stall_cnt),      64'd4);

        // ---- asynchronous reset mid-burst ----
        ej_ready = 1'b0;
        drive_ring(1'b1, 5'd3, 36'h111, 64'h11, PKT_RESP);
        drive_inj(1'b1, 5'd9, 36'h900, 64'h90);
        step();
        check_eq("pre_rst_bounce", 64'(bounce_cnt),     64'd2);
        check_eq("pre_rst_out_v",  64'(ring_out_valid), 64'd1);
        check_eq("pre_rst_count",  64'(inj_count),      64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_ring_out_valid", 64'(ring_out_valid), 64'd0);
        check_eq("arst_ring_out_data",  ring_out_data[63:0], 64'd0);
        check_eq("arst_ej_valid",       64'(ej_valid),       64'd0);
        check_eq("arst_ej_data",        ej_data[63:0],       64'd0);
        check_eq("arst_inj_count",      64'(inj_count),      64'd0);
        check_eq("arst_inj_ready",      64'(inj_ready),      64'd0);
        check_eq("arst_bounce_cnt",     64'(bounce_cnt),     64'd0);
        check_eq("arst_stall_cnt",      64'(stall_cnt),      64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_node_stage.md
# ring_node_stage

Registered, parametrised ring-bus stop; the next generation of the combinational ring tap used between memory clients. Each instance owns one slot position on a unidirectional packet ring. It ejects packets addressed to its `NODE_ID` into a local output register and inserts locally queued packets into free slots. It adds one register stage per hop, so ring length no longer limits cycle time.

## Interface
Parameters:
- `DATA_W`, 512: payload width
- `ADDR_W`, 36: address width
- `ID_W`, 5: destination node id width
- `NODE_ID`, 0: this stop's id
- `INJ_DEPTH`, 4: inject FIFO entries; power of two, ≥2
- `CNT_W`, 16: statistics counter width

Ports (`*_addr`/`*_data`/`*_id`/`*_type` are ADDR_W/DATA_W/ID_W/3 bits; a "packet" below means valid plus these four fields):
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: **asynchronous, active-low** reset
- `ring_in_valid`, `ring_in_addr`, `ring_in_data`, `ring_in_id`, `ring_in_type` in: packet from the upstream stop
- `ring_out_valid`, `ring_out_addr`, `ring_out_data`, `ring_out_id`, `ring_out_type` out: registered packet to the downstream stop
- `inj_valid` in 1, `inj_ready` out 1, `inj_addr/data/id/type` in: local inject request; `inj_id` is the destination
- `ej_valid` out 1, `ej_ready` in 1, `ej_addr/data/id/type` out: ejected packet to the local client
- `inj_count` out $clog2(INJ_DEPTH)+1: FIFO occupancy
- `bounce_cnt` out CNT_W: saturating count of packets that matched but could not eject
- `stall_cnt` out CNT_W: saturating count of cycles FIFO non-empty and no free slot

## Operation
- `match` = `ring_in_valid && ring_in_id == NODE_ID`.
- Eject register is free when `!ej_valid || ej_ready`. If `match` and free: load ring_in into eject register; slot becomes empty.
- If `match` and eject register not free: packet bounces. It forwards unchanged to ring_out and returns after a full lap. `bounce_cnt` increments.
- `slot_free` = `!ring_in_valid || (match && ejected)`.
- If `slot_free` and FIFO non-empty: ring_out register takes FIFO head; pop.
- Otherwise ring_out takes ring_in (`valid` = 0 when ejected and nothing inserted).
- Pass-through traffic has absolute priority over insertion; there is no fairness mechanism.
- `stall_cnt` increments when the FIFO is non-empty and the slot is not free.
- FIFO: `inj_ready` = `inj_count < INJ_DEPTH`, registered-count based, with no same-cycle pop bypass. Push on `inj_valid && inj_ready`. Push and pop in the same cycle keep the count unchanged.
- An injected packet with `inj_id == NODE_ID` circulates one full lap and is then ejected here.
- Data fields of ring_out and ej are don't-care when the corresponding valid is 0, but are held stable while `ej_valid && !ej_ready`.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asserted asynchronously): `ring_out_valid` = 0, `ej_valid` = 0, `inj_count` = 0, `inj_ready` = 0 while `rst` is low, then 1. Counters and all data outputs = 0. FIFO contents are discarded.
- Reset mid-operation drops any in-flight ring, eject, or FIFO packet; there is no partial delivery.
- Hop latency: ring_in in cycle N appears on ring_out in cycle N+1.
- Eject latency: match in cycle N gives `ej_valid` in cycle N+1. Back-to-back ejects are sustained at 1/cycle while `ej_ready` = 1.
- Inject latency: handshake in cycle N with an empty FIFO and `slot_free` in cycle N+1 gives `ring_out_valid` in cycle N+2.
- Simultaneous events in one cycle: match + eject-full + FIFO non-empty means bounce, no insert, and `stall_cnt`++. Match + eject-free + FIFO non-empty means eject and insert in the same slot.

## Structure
- `ring_pkg`:
  - `ring_pkt_t` struct (valid, addr, data, id, type), parametrised via package localparams matching the defaults
  - packet-type localparams (`PKT_READ`, `PKT_WRITE`, `PKT_RESP`, ...)
- Sub-module `ring_inject_fifo`: synchronous FIFO with valid/ready push, pop, and count. Pointer width $clog2(INJ_DEPTH) with wrap, plus a separate count register.

## Test plan
- Pass-through: NODE_ID=3, packet id=5 addr=0x123 on ring_in in cycle 10 -> ring_out identical in cycle 11; `ej_valid` stays 0.
- Eject: id=3 data=0xAB in cycle 10 with `ej_ready`=1 -> `ej_valid`=1, data 0xAB in cycle 11; `ring_out_valid`=0 in cycle 11.
- Bounce: hold `ej_ready`=0 with eject register full; id=3 arrives -> forwarded on ring_out next cycle, `bounce_cnt`=1, eject data unchanged.
- Inject/priority: push 4 packets with ring_in saturated (valid, id≠3) -> `inj_ready`=0 after 4th, `stall_cnt` increments each cycle. Drop ring_in_valid -> packets exit in FIFO order on 4 consecutive cycles.
- Eject+insert same slot: FIFO holds id=7; id=3 arrives, `ej_ready`=1 -> next cycle `ej_valid`=1 and ring_out carries id=7.
- Async reset: assert `rst`=0 mid-burst between edges -> `ring_out_valid`, `ej_valid`, `inj_count`, counters all 0 immediately, without waiting for a clock edge.
